// File: rtl/div_period_mon.sv
// Divided-clock period monitor: measures high/low phase lengths of div_in in clk cycles,
// checks them against expected lengths, reports lock and errors. Optional DIV_MON_SYNC_EN adds a 2-flop input synchronizer.
module div_period_mon #(
   parameter int CNT_W  = 16,
   parameter int TOL    = 1,
   parameter int LOCK_N = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_in,
   input  logic [CNT_W-1:0] exp_high,
   input  logic [CNT_W-1:0] exp_low,
   input  logic             err_clr,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic             phase_valid,
   output logic             locked,
   output logic             err,
   output logic [7:0]       err_cnt
);

   typedef enum logic [0:0] {
      WAIT_EDGE = 1'b0,
      MEASURE   = 1'b1
   } state_t;

   localparam int               GR_W    = $clog2(LOCK_N + 1);
   localparam logic [GR_W-1:0]  LOCK_V  = GR_W'(LOCK_N);
   localparam logic [GR_W-1:0]  GR_ONE  = GR_W'(1);
   localparam logic [CNT_W:0]   TOL_X   = (CNT_W + 1)'(TOL);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_r, state_nxt_s;
   logic             lvl_src_s;
   logic             lvl_r, lvl_d_r;
   logic             edge_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] high_cnt_r, low_cnt_r;
   logic             phase_valid_r, locked_r, err_r;
   logic [7:0]       err_cnt_r;
   logic [GR_W-1:0]  gr_r, gr_inc_s;
   logic [CNT_W:0]   cnt_x_s, lim_s, exp_fin_x_s, diff_s;
   logic             cap_s, good_s, bad_s;

`ifdef DIV_MON_SYNC_EN
   logic sync1_r, sync2_r;

   // two-flop synchronizer for an asynchronous div_in
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= div_in;
         sync2_r <= sync1_r;
      end
   end

   assign lvl_src_s = sync2_r;
`else
   assign lvl_src_s = div_in;
`endif

   // level register, its delayed copy and the saturating phase counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_r   <= 1'b0;
         lvl_d_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         lvl_r   <= lvl_src_s;
         lvl_d_r <= lvl_r;
         if (edge_s) begin
            cnt_r <= CNT_ONE;
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign edge_s = lvl_r ^ lvl_d_r;

   // Timeout uses the level now being held; the phase check uses the level that just ended.
   assign cnt_x_s     = {1'b0, cnt_r};
   assign lim_s       = {1'b0, (lvl_r ? exp_high : exp_low)} + TOL_X;
   assign exp_fin_x_s = {1'b0, (lvl_d_r ? exp_high : exp_low)};
   assign diff_s      = (cnt_x_s > exp_fin_x_s) ? (cnt_x_s - exp_fin_x_s) : (exp_fin_x_s - cnt_x_s);
   assign gr_inc_s    = (gr_r == LOCK_V) ? gr_r : (gr_r + GR_ONE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= WAIT_EDGE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next state plus capture / good / bad decisions
   always_comb begin
      state_nxt_s = state_r;
      cap_s       = 1'b0;
      good_s      = 1'b0;
      bad_s       = 1'b0;
      case (state_r)
         WAIT_EDGE: begin
            if (edge_s) begin
               state_nxt_s = MEASURE;
            end else begin
               state_nxt_s = WAIT_EDGE;
            end
         end
         MEASURE: begin
            if (edge_s) begin
               cap_s = 1'b1;
               if (diff_s <= TOL_X) begin
                  good_s = 1'b1;
               end else begin
                  bad_s = 1'b1;
               end
            end else if (cnt_x_s > lim_s) begin
               bad_s       = 1'b1;
               state_nxt_s = WAIT_EDGE;
            end else begin
               state_nxt_s = MEASURE;
            end
         end
         default: begin
            state_nxt_s = WAIT_EDGE;
         end
      endcase
   end

   // registered outputs, lock run and saturating error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_cnt_r    <= '0;
         low_cnt_r     <= '0;
         phase_valid_r <= 1'b0;
         err_r         <= 1'b0;
         locked_r      <= 1'b0;
         gr_r          <= '0;
         err_cnt_r     <= 8'd0;
      end else begin
         phase_valid_r <= cap_s;
         err_r         <= bad_s;
         if (cap_s && lvl_d_r) begin
            high_cnt_r <= cnt_r;
         end else if (cap_s) begin
            low_cnt_r <= cnt_r;
         end
         if (bad_s) begin
            gr_r     <= '0;
            locked_r <= 1'b0;
         end else if (good_s) begin
            gr_r     <= gr_inc_s;
            locked_r <= (gr_inc_s == LOCK_V);
         end
         if (err_clr) begin
            err_cnt_r <= bad_s ? 8'd1 : 8'd0;
         end else if (bad_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
         end
      end
   end

   assign high_cnt    = high_cnt_r;
   assign low_cnt     = low_cnt_r;
   assign phase_valid = phase_valid_r;
   assign locked      = locked_r;
   assign err         = err_r;
   assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_div_period_mon.sv
// Directed bench for div_period_mon: lock, timeout, saturation, err_clr, mid-phase reset
// and (with DIV_MON_SYNC_EN) an asynchronous 6/6 input.
module tb_div_period_mon;

`ifdef DIV_MON_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        div_in;
   logic [15:0] exp_high, exp_low;
   logic        err_clr;
   logic [15:0] high_cnt, low_cnt;
   logic        phase_valid, locked, err;
   logic [7:0]  err_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int pv_n  = 0;
   int err_n = 0;
   int mn    = 1000;
   int mx    = 0;
   logic trk = 1'b0;
   int p0, e0;

   div_period_mon #(.CNT_W(16), .TOL(1), .LOCK_N(4)) dut (
      .clk(clk), .rst_n(rst_n), .div_in(div_in),
      .exp_high(exp_high), .exp_low(exp_low), .err_clr(err_clr),
      .high_cnt(high_cnt), .low_cnt(low_cnt), .phase_valid(phase_valid),
      .locked(locked), .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // pulse counters and length range, sampled on the inactive edge
   always @(negedge clk) begin
      if (phase_valid) pv_n <= pv_n + 1;
      if (err) err_n <= err_n + 1;
      if (phase_valid && trk) begin
         if (int'(high_cnt) < mn) mn <= int'(high_cnt);
         if (int'(low_cnt) > mx) mx <= int'(low_cnt);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         div_in = 1'b1;
         cyc(hi);
         div_in = 1'b0;
         cyc(lo);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   initial begin
      rst_n = 1'b0; div_in = 1'b0; err_clr = 1'b0;
      exp_high = 16'd5; exp_low = 16'd7;
      cyc(2);
      chk("rst_high_cnt", 32'(high_cnt), 32'd0);
      chk("rst_low_cnt", 32'(low_cnt), 32'd0);
      chk("rst_pv", 32'(phase_valid), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst_n = 1'b1;

      // steady 5/7: first edge discarded, lock on 4th reported phase
      wave(5, 7, 2);
      chk("sq_pv_n", 32'(pv_n), 32'd3);
      chk("sq_high", 32'(high_cnt), 32'd5);
      chk("sq_low", 32'(low_cnt), 32'd7);
      chk("sq_unlocked3", 32'(locked), 32'd0);
      div_in = 1'b1;
      cyc(LAT);
      chk("sq_lock_early", 32'(locked), 32'd0);
      cyc(1);
      chk("sq_lock_pv", 32'(phase_valid), 32'd1);
      chk("sq_lock", 32'(locked), 32'd1);
      cyc(4 - LAT);
      div_in = 1'b0;
      cyc(7);
      wave(5, 7, 1);
      chk("sq_locked_hold", 32'(locked), 32'd1);
      chk("sq_err_cnt", 32'(err_cnt), 32'd0);
      chk("sq_err_n", 32'(err_n), 32'd0);

      // 8-cycle high phase: timeout once counter reaches 7
      p0 = pv_n; e0 = err_n;
      div_in = 1'b1;
      cyc(8);
      chk("to_no_err_early", 32'(err_n), 32'(e0));
      div_in = 1'b0;
      cyc(LAT);
      chk("to_err", 32'(err), 32'd1);
      chk("to_unlock", 32'(locked), 32'd0);
      chk("to_err_cnt", 32'(err_cnt), 32'd1);
      cyc(1);
      chk("to_err_pulse", 32'(err), 32'd0);
      cyc(6 - LAT);
      chk("to_not_reported", 32'(pv_n), 32'(p0 + 1));
      chk("to_high_kept", 32'(high_cnt), 32'd5);
      wave(5, 7, 1);
      chk("relock_pending", 32'(locked), 32'd0);
      wave(5, 7, 1);
      chk("relock", 32'(locked), 32'd1);

      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      chk("clr_err_cnt", 32'(err_cnt), 32'd0);

      // stuck high: one error, then silence
      e0 = err_n;
      div_in = 1'b1;
      cyc(40);
      chk("stuck_one_err", 32'(err_n), 32'(e0 + 1));
      chk("stuck_err_cnt", 32'(err_cnt), 32'd1);
      chk("stuck_unlock", 32'(locked), 32'd0);
      cyc(40);
      chk("stuck_silent", 32'(err_n), 32'(e0 + 1));

      // 3-cycle low phases against exp_low=7, then saturation
      for (int i = 0; i < 11; i++) begin
         div_in = 1'b0; cyc(3);
         div_in = 1'b1; cyc(5);
      end
      chk("bad11_err_cnt", 32'(err_cnt), 32'd12);
      chk("bad11_low", 32'(low_cnt), 32'd3);
      chk("bad11_unlocked", 32'(locked), 32'd0);
      for (int i = 0; i < 289; i++) begin
         div_in = 1'b0; cyc(3);
         div_in = 1'b1; cyc(5);
      end
      chk("sat_err_cnt", 32'(err_cnt), 32'd255);

      // err_clr coinciding with an err pulse
      div_in = 1'b0;
      cyc(3);
      div_in = 1'b1;
      cyc(LAT);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      chk("clr_with_err_pulse", 32'(err), 32'd1);
      chk("clr_with_err_cnt", 32'(err_cnt), 32'd1);

      // lock again, then reset mid-phase
      cyc(4 - LAT);
      div_in = 1'b0;
      cyc(7);
      wave(5, 7, 3);
      chk("pre_rst_locked", 32'(locked), 32'd1);
      chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
      div_in = 1'b1;
      cyc(2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_high", 32'(high_cnt), 32'd0);
      chk("mid_rst_low", 32'(low_cnt), 32'd0);
      chk("mid_rst_locked", 32'(locked), 32'd0);
      chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("mid_rst_pv", 32'(phase_valid), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      cyc(1);
      rst_n = 1'b1;
      cyc(4);
      div_in = 1'b0;
      cyc(7);
      chk("post_rst_high4", 32'(high_cnt), 32'd4);
      wave(5, 7, 1);
      chk("post_rst_unlocked", 32'(locked), 32'd0);
      div_in = 1'b1;
      cyc(LAT + 1);
      chk("post_rst_relock", 32'(locked), 32'd1);
      chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

`ifdef DIV_MON_SYNC_EN
      // asynchronous nominal 6/6 input
      exp_high = 16'd6; exp_low = 16'd6;
      #3;
      for (int i = 0; i < 5; i++) begin
         #61 div_in = 1'b0;
         #59 div_in = 1'b1;
      end
      @(negedge clk);
      e0 = err_n;
      trk = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #61 div_in = 1'b0;
         #59 div_in = 1'b1;
      end
      @(negedge clk);
      trk = 1'b0;
      chk("async_no_err", 32'(err_n), 32'(e0));
      chk("async_locked", 32'(locked), 32'd1);
      chk("async_min_ok", 32'(mn >= 5), 32'd1);
      chk("async_max_ok", 32'(mx <= 7), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
